// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that grants one of N_REQ requesters at a time and loads
// its data word into a single shared register, returning a one-cycle ack.
`timescale 1ns/1ps

module shared_reg_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    output logic [N_REQ-1:0]       ack,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy,
    output logic [WIDTH-1:0]       data_out,
    output logic                   data_valid
);

    // state | meaning
    // IDLE  | waiting for any req; arbitrates from rr_ptr upward
    // GRANT | winner latched; write on this edge if its req is still high
    // DONE  | ack high for one cycle; req ignored (turnaround)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [IDW-1:0]   rr_ptr, rr_ptr_n;
    logic [IDW-1:0]   grant_id_n;
    logic             busy_n;
    logic [N_REQ-1:0] ack_n;
    logic [WIDTH-1:0] data_out_n;
    logic             data_valid_n;

    logic [WIDTH-1:0] words [N_REQ];
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   cand;
    logic             found;

    for (genvar i = 0; i < N_REQ; i++) begin : g_words
        assign words[i] = data_in[i*WIDTH +: WIDTH];
    end

    // Scan downward so the smallest offset from rr_ptr is the last to win.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        cand   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr) + k) % N_REQ);
            if (req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_n      = state;
        rr_ptr_n     = rr_ptr;
        grant_id_n   = grant_id;
        busy_n       = busy;
        ack_n        = '0;
        data_out_n   = data_out;
        data_valid_n = data_valid;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_id_n = winner;
                    busy_n     = 1'b1;
                    state_n    = GRANT;
                end
            end
            GRANT: begin
                if (req[grant_id]) begin
                    data_out_n      = words[grant_id];
                    ack_n[grant_id] = 1'b1;
                    data_valid_n    = 1'b1;
                    rr_ptr_n        = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state_n         = DONE;
                end else begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            ack        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_n;
            rr_ptr     <= rr_ptr_n;
            grant_id   <= grant_id_n;
            busy       <= busy_n;
            ack        <= ack_n;
            data_out   <= data_out_n;
            data_valid <= data_valid_n;
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: expected writes are queued when a
// request is driven and popped when the DUT pulses ack.
`timescale 1ns/1ps

module tb_shared_reg_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = $clog2(N_REQ);

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] data_in;
    logic [N_REQ-1:0]       ack;
    logic [IDW-1:0]         grant_id;
    logic                   busy;
    logic [WIDTH-1:0]       data_out;
    logic                   data_valid;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    shared_reg_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data_in    (data_in),
        .ack        (ack),
        .grant_id   (grant_id),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic [WIDTH-1:0] d);
        exp_t e;
        e.idx = idx;
        e.d   = d;
        sb.push_back(e);
    endtask

    task automatic set_word(input int idx, input logic [WIDTH-1:0] d);
        data_in[idx*WIDTH +: WIDTH] = d;
    endtask

    // Advance until ack pulses (bounded), then compare against the queue head.
    task automatic wait_ack(input string tag, input int budget, output int n);
        exp_t             e;
        logic [N_REQ-1:0] exp_ack;
        n = 0;
        do begin
            tick();
            n++;
        end while (ack == '0 && n < budget);
        chk({tag, "_ack_seen"}, 32'(ack != '0), 32'd1);
        if (ack != '0) begin
            chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e       = sb.pop_front();
                exp_ack = '0;
                exp_ack[e.idx] = 1'b1;
                chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
                chk({tag, "_data_out"}, 32'(data_out), 32'(e.d));
            end
        end
    endtask

    initial begin
        int n;
        int stray;

        reset   = 1'b1;
        req     = '0;
        data_in = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);

        // single requester 2
        set_word(2, 8'h5A);
        req = 4'b0100;
        push(2, 8'h5A);
        tick();
        chk("t1_grant_id", 32'(grant_id), 32'd2);
        chk("t1_busy_grant", 32'(busy), 32'd1);
        chk("t1_no_ack_e0", 32'(ack), 32'h0);
        wait_ack("t1", 5, n);
        chk("t1_latency", 32'(n), 32'd1);
        req = '0;
        tick();
        chk("t1_ack_clear", 32'(ack), 32'h0);
        chk("t1_busy_low", 32'(busy), 32'd0);
        chk("t1_valid", 32'(data_valid), 32'd1);

        // pointer now 3: req 3 beats req 0, then wraps to 0
        data_in = {8'h40, 8'h30, 8'h20, 8'h10};
        req = 4'b1001;
        push(3, 8'h40);
        push(0, 8'h10);
        wait_ack("t3a", 10, n);
        req = 4'b0001;
        wait_ack("t3b", 10, n);
        chk("t3_spacing", 32'(n), 32'd3);
        req = '0;
        tick();
        chk("t3_busy_low", 32'(busy), 32'd0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // all four held: 0,1,2,3,0 every 3 cycles
        req = 4'b1111;
        push(0, 8'h10);
        push(1, 8'h20);
        push(2, 8'h30);
        push(3, 8'h40);
        push(0, 8'h10);
        for (int i = 0; i < 5; i++) begin
            wait_ack($sformatf("t2_%0d", i), 10, n);
            if (i > 0) chk($sformatf("t2_spacing_%0d", i), 32'(n), 32'd3);
        end
        req = '0;
        tick();
        tick();
        chk("t2_busy_low", 32'(busy), 32'd0);
        chk("t2_ack_low", 32'(ack), 32'h0);

        // pointer 1: requester 1 withdraws during GRANT
        req = 4'b0010;
        tick();
        chk("t4_grant_id", 32'(grant_id), 32'd1);
        chk("t4_busy", 32'(busy), 32'd1);
        req = '0;
        tick();
        chk("t4_no_ack", 32'(ack), 32'h0);
        chk("t4_busy_low", 32'(busy), 32'd0);
        chk("t4_data_kept", 32'(data_out), 32'h10);
        tick();
        chk("t4_still_no_ack", 32'(ack), 32'h0);
        // pointer unchanged at 1, so 1 beats 3
        req = 4'b1010;
        push(1, 8'h20);
        wait_ack("t4_rereq", 10, n);
        req = '0;
        tick();

        // pointer 2: data changed after the GRANT edge is ignored
        set_word(0, 8'h11);
        req = 4'b0001;
        push(0, 8'h11);
        tick();
        chk("t6_grant_id", 32'(grant_id), 32'd0);
        wait_ack("t6", 5, n);
        set_word(0, 8'h22);
        req = '0;
        tick();
        chk("t6_hold_1", 32'(data_out), 32'h11);
        tick();
        chk("t6_hold_2", 32'(data_out), 32'h11);

        // reset asserted while in DONE
        set_word(3, 8'hC3);
        req = 4'b1000;
        push(3, 8'hC3);
        wait_ack("t5", 10, n);
        reset = 1'b1;
        #1;
        chk("t5_ack_async", 32'(ack), 32'h0);
        chk("t5_busy_async", 32'(busy), 32'h0);
        chk("t5_data_async", 32'(data_out), 32'h0);
        chk("t5_valid_async", 32'(data_valid), 32'h0);
        req = '0;
        tick();
        reset = 1'b0;
        stray = 0;
        repeat (6) begin
            tick();
            if (ack != '0 || busy) stray++;
        end
        chk("t5_no_stray_ack", 32'(stray), 32'd0);
        set_word(2, 8'h77);
        req = 4'b0100;
        push(2, 8'h77);
        wait_ack("t5_new", 10, n);
        req = '0;
        tick();
        chk("t5_valid_again", 32'(data_valid), 32'd1);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
